// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: drives data-memory req/ack accesses, stalls M while busy, owns MEM/WB.
// Optional MEM_TIMEOUT_EN adds an access-timeout counter and sticky o_MemErr.
module mem_stage_ctrl #(
   parameter int D_WIDTH        = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_PCSrcM,
   input  logic               i_RegWriteM,
   input  logic               i_MemtoRegM,
   input  logic               i_MemWriteM,
   input  logic [D_WIDTH-1:0] i_ALUResultM,
   input  logic [D_WIDTH-1:0] i_WriteDataM,
   input  logic [3:0]         i_WA3M,
   output logic               o_StallM,
   output logic               o_dmem_req,
   output logic               o_dmem_we,
   output logic [D_WIDTH-1:0] o_dmem_addr,
   output logic [D_WIDTH-1:0] o_dmem_wdata,
   input  logic               i_dmem_ack,
   input  logic [D_WIDTH-1:0] i_dmem_rdata,
   output logic               o_PCSrcW,
   output logic               o_RegWriteW,
   output logic               o_MemtoRegW,
   output logic [D_WIDTH-1:0] o_ReadDataW,
   output logic [D_WIDTH-1:0] o_ALUOutW,
   output logic [3:0]         o_WA3W,
   output logic               o_MemErr
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t             state_q, state_d;
   logic [D_WIDTH-1:0] addr_q, addr_d;
   logic [D_WIDTH-1:0] wdata_q, wdata_d;
   logic [D_WIDTH-1:0] rdata_q, rdata_d;
   logic               we_q, we_d;
   logic               mem_op;
   logic               timeout;

   assign mem_op   = i_MemtoRegM | i_MemWriteM;
   assign o_StallM = ((state_q == IDLE) && mem_op) || (state_q == ACCESS);

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   // An ack in the final cycle takes priority over the timeout.
   assign timeout = (state_q == ACCESS) && !i_dmem_ack &&
                    (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (state_q != ACCESS) begin
         cnt_d = '0;
      end else if (!i_dmem_ack) begin
         cnt_d = cnt_q + 1'b1;
      end
      if (timeout) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign o_MemErr = err_q;
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout            = 1'b0;
   assign o_MemErr           = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      we_d    = we_q;
      case (state_q)
         IDLE: begin
            if (mem_op) begin
               addr_d  = i_ALUResultM;
               wdata_d = i_WriteDataM;
               we_d    = i_MemWriteM;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (i_dmem_ack) begin
               if (!we_q) begin
                  rdata_d = i_dmem_rdata;
               end
               state_d = DONE;
            end else if (timeout) begin
               rdata_d = '0;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         we_q    <= we_d;
      end
   end

   assign o_dmem_req   = (state_q == ACCESS);
   assign o_dmem_we    = we_q;
   assign o_dmem_addr  = addr_q;
   assign o_dmem_wdata = wdata_q;

   // MEM/WB: a stalled cycle is a bubble; data fields simply hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_PCSrcW    <= 1'b0;
         o_RegWriteW <= 1'b0;
         o_MemtoRegW <= 1'b0;
         o_ReadDataW <= '0;
         o_ALUOutW   <= '0;
         o_WA3W      <= '0;
      end else if (o_StallM) begin
         o_PCSrcW    <= 1'b0;
         o_RegWriteW <= 1'b0;
      end else begin
         o_PCSrcW    <= i_PCSrcM;
         o_RegWriteW <= i_RegWriteM;
         o_MemtoRegW <= i_MemtoRegM & ~i_MemWriteM;
         o_ReadDataW <= (state_q == DONE) ? rdata_q : '0;
         o_ALUOutW   <= i_ALUResultM;
         o_WA3W      <= i_WA3M;
      end
   end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller that consumes the EX/MEM pipeline register outputs. It performs loads and stores against the data memory over a req/ack handshake and stalls the front of the pipeline while an access is outstanding. It also holds the MEM/WB pipeline register that feeds writeback, inserting a bubble into WB for every stalled cycle.

## Interface
Parameters:
- D_WIDTH, 32, datapath width (matches `D_WIDTH)
- TIMEOUT_CYCLES, 255, max ACCESS cycles before abort (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_PCSrcM, i_RegWriteM, i_MemtoRegM, i_MemWriteM  in  1 each  M-stage control bits
- i_ALUResultM  in  D_WIDTH  address for memory ops, result otherwise
- i_WriteDataM  in  D_WIDTH  store data
- i_WA3M  in  4  destination register
- o_StallM  out  1  hold EX/MEM and earlier stages
- o_dmem_req  out  1  access request
- o_dmem_we  out  1  1 = store, 0 = load
- o_dmem_addr, o_dmem_wdata  out  D_WIDTH  access address and store data
- i_dmem_ack  in  1  access complete
- i_dmem_rdata  in  D_WIDTH  load data, valid with ack
- o_PCSrcW, o_RegWriteW, o_MemtoRegW  out  1 each  WB control
- o_ReadDataW, o_ALUOutW  out  D_WIDTH  WB data
- o_WA3W  out  4  WB destination
- o_MemErr  out  1  sticky access-timeout flag

## Operation
- A memory op is present when i_MemtoRegM is high (load) or i_MemWriteM is high (store). If both are high, the access is treated as a store.
- FSM states IDLE, ACCESS, DONE. Reset state is IDLE.
  - IDLE, memory op present: latch address, write data and we; go to ACCESS.
  - IDLE, no memory op: stay in IDLE.
  - ACCESS: wait for i_dmem_ack. On ack, latch i_dmem_rdata (loads only) and go to DONE.
  - DONE: go to IDLE unconditionally.
- o_StallM = (IDLE && memory op present) || ACCESS. The signal is combinational and is low in DONE.
- o_dmem_req = (state == ACCESS) and is registered-state driven. o_dmem_addr, o_dmem_wdata and o_dmem_we are stable for the whole ACCESS period.
- i_dmem_ack is ignored outside ACCESS.
- MEM/WB register update, each edge:
  - If o_StallM is high: o_RegWriteW and o_PCSrcW load 0 (bubble). Other WB fields are don't-care but hold their previous values.
  - Otherwise: load the M-stage control bits, i_ALUResultM and i_WA3M. o_ReadDataW loads the latched load data when leaving DONE, and loads 0 for non-memory ops.
- A store writes o_MemtoRegW = 0 and o_RegWriteW = i_RegWriteM, which is normally 0.

## Timing
- Reset values: all outputs are 0; state is IDLE; the latched address, write data and read data are 0.
- A reset asserted mid-access drops o_dmem_req on the next edge with no abort handshake. A late ack after reset is ignored.
- Non-memory instruction: occupies M for 1 cycle, reaches W on the next edge, no stall.
- Memory instruction with ack arriving in ACCESS cycle k (k ≥ 1):
  - Occupies M for 2 + k cycles: 1 IDLE, k ACCESS, 1 DONE.
  - Produces 1 + k bubbles in WB.
  - Its WB entry appears on the edge ending DONE.
- Back-to-back memory ops: the second enters IDLE immediately after DONE. There is no idle gap beyond the DONE cycle.

## Configuration
- MEM_TIMEOUT_EN defined:
  - An 8..16-bit counter clears on ACCESS entry and increments every ACCESS cycle without ack.
  - On reaching TIMEOUT_CYCLES, the FSM goes to DONE with read data 0 and sets o_MemErr.
  - o_MemErr stays high until rst.
  - An ack in the same cycle as the timeout wins: completes normally, no error.
- MEM_TIMEOUT_EN undefined: ACCESS waits indefinitely, no counter is present, and o_MemErr is tied to 0.

## Test plan
- Reset: assert rst for 2 cycles during ACCESS with req high → next edge has req=0, state IDLE, all W outputs 0, o_StallM=0 with no memory op.
- ALU op: i_RegWriteM=1, i_ALUResultM=0x1234, i_WA3M=5 → 1 cycle later o_RegWriteW=1, o_ALUOutW=0x1234, o_WA3W=5, with no stall.
- Load with ack 3 cycles after req, rdata=0xDEADBEEF, addr=0x40:
  - o_StallM high for 4 cycles, req high for 3 cycles, addr=0x40, we=0.
  - WB bubbles while stalled.
  - Then o_ReadDataW=0xDEADBEEF, o_MemtoRegW=1.
- Store addr=0x80, data=0xA5A5A5A5, ack in the first ACCESS cycle → we=1, wdata stable, stall 2 cycles, o_RegWriteW=0 throughout.
- Back-to-back load then store → two distinct accesses, no duplicate req for either, and the WB order is preserved.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, ack never asserted → DONE after 8 ACCESS cycles, o_ReadDataW=0, o_MemErr=1 until rst.
